// File: rtl/ov7670_stream_gen.sv
`timescale 1ns/1ps
// Transmit-side OV7670 parallel bus model: emits vsync/href and RGB444 byte pairs
// with programmable blanking and four built-in test patterns, one byte per clk.
module ov7670_stream_gen #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int LINE_B   = 2 * IMG_W + HBLANK;
  localparam int CW       = $clog2(LINE_B);
  localparam int MAX_A    = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_B    = (IMG_H > VFP_LINES) ? IMG_H : VFP_LINES;
  localparam int LINE_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_B - 1);
  localparam logic [CW-1:0] ACT_BYTES = CW'(2 * IMG_W);
  localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST  = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] ACT_LAST  = LW'(IMG_H - 1);
  localparam logic [LW-1:0] VFP_LAST  = LW'(VFP_LINES - 1);

  // Colour bar palette, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  // With no vsync lines the frame begins directly in the back porch.
  localparam state_t FIRST_STATE = (VSYNC_LINES > 0) ? S_VSYNC : S_VBP;

  state_t        state, next_state;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [1:0]    mode_q;
  logic [11:0]   solid_q;

  logic        eol, last_line, start_frame, first_byte, href_d, chk;
  logic [31:0] x, y;
  logic [2:0]  bar;
  logic [3:0]  lvl;
  logic [11:0] rgb;
  logic [7:0]  data_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eol        = (col == COL_LAST);
    last_line  = 1'b0;
    next_state = S_IDLE;
    case (state)
      S_VSYNC:  begin last_line = (line == VS_LAST);  next_state = S_VBP;    end
      S_VBP:    begin last_line = (line == VBP_LAST); next_state = S_ACTIVE; end
      S_ACTIVE: begin last_line = (line == ACT_LAST); next_state = S_VFP;    end
      S_VFP:    begin last_line = (line == VFP_LAST); next_state = S_IDLE;   end
      default:  ;
    endcase

    start_frame = enable && ((state == S_IDLE) || (state == S_VFP && eol && last_line));
    first_byte  = (state == FIRST_STATE) && (col == '0) && (line == '0);
    href_d      = (state == S_ACTIVE) && (col < ACT_BYTES);

    x   = 32'(col) >> 1;
    y   = 32'(line);
    bar = 3'((x * 32'd8) / IMG_W);
    lvl = 4'((x * 32'd16) / IMG_W);
    chk = ((x ^ y) & 32'h20) != 32'h0;

    rgb = solid_q;
    case (mode_q)
      2'd0:    rgb = BAR_RGB[bar];
      2'd1:    rgb = {lvl, lvl, lvl};
      2'd2:    rgb = chk ? 12'h000 : 12'hFFF;
      default: rgb = solid_q;
    endcase

    // Even byte carries R in the low nibble, odd byte carries {G,B}.
    data_d = 8'h00;
    if (href_d) data_d = col[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      col         <= '0;
      line        <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= 8'h00;
      frame_start <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      // Outputs are decoded from the counter state one cycle behind it.
      vsync       <= (state == S_VSYNC);
      href        <= href_d;
      data        <= data_d;
      frame_start <= first_byte;
      if (first_byte) frame_count <= frame_count + 16'd1;

      if (start_frame) begin
        state   <= FIRST_STATE;
        col     <= '0;
        line    <= '0;
        mode_q  <= mode;
        solid_q <= solid_rgb;
      end else if (state != S_IDLE) begin
        if (eol) begin
          col <= '0;
          if (last_line) begin
            line  <= '0;
            state <= next_state;
          end else begin
            line <= line + LW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
`timescale 1ns/1ps
// Directed bench for ov7670_stream_gen on a tiny 8x4 frame (LINE_B=20, 140 cycles/frame).
module tb_ov7670_stream_gen;

  localparam int IMG_W       = 8;
  localparam int IMG_H       = 4;
  localparam int HBLANK      = 4;
  localparam int VSYNC_LINES = 1;
  localparam int VBP_LINES   = 1;
  localparam int VFP_LINES   = 1;
  localparam int FRAME_CYC   = 140;

  localparam int EV_NONE = 0;
  localparam int EV_MODE = 1;
  localparam int EV_DROP = 2;
  localparam int EV_RST  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        frame_start;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .HBLANK(HBLANK),
    .VSYNC_LINES(VSYNC_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .vsync(vsync), .href(href), .data(data), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-written pixel table for an 8-pixel-wide line.
  function automatic logic [11:0] exp_pix(input logic [1:0] m, input logic [11:0] s, input int x);
    case (m)
      2'd0: case (x)
              0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
              4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
            endcase
      2'd1: case (x)
              0: return 12'h000;  1: return 12'h222;  2: return 12'h444;  3: return 12'h666;
              4: return 12'h888;  5: return 12'hAAA;  6: return 12'hCCC;  default: return 12'hEEE;
            endcase
      2'd2:    return 12'hFFF;
      default: return s;
    endcase
  endfunction

  task automatic check_idle(input string tag, input logic [15:0] cnt);
    check({tag, " vsync"},       16'(vsync),       16'h0);
    check({tag, " href"},        16'(href),        16'h0);
    check({tag, " data"},        16'(data),        16'h0);
    check({tag, " frame_start"}, 16'(frame_start), 16'h0);
    check({tag, " frame_count"}, frame_count,      cnt);
  endtask

  // Steps through one frame starting at its first vsync-high cycle (k=1) and
  // checks every output each cycle; an optional event is applied after cycle evt_k.
  task automatic run_frame(input string name, input logic [1:0] m, input logic [11:0] s,
                           input logic [15:0] cnt, input int evt_k, input int evt_kind,
                           input logic [1:0] new_mode, input logic [11:0] new_solid);
    int          href_n;
    int          p;
    int          ln;
    logic        ev;
    logic        eh;
    logic [11:0] px;
    logic [7:0]  ed;
    href_n = 0;
    for (int k = 1; k <= FRAME_CYC; k++) begin
      step();
      p  = (k - 1) % 20;
      ln = (k - 1) / 20;
      ev = (ln == 0);
      eh = (ln >= 2) && (ln <= 5) && (p < 16);
      px = exp_pix(m, s, p / 2);
      ed = !eh ? 8'h00 : ((p % 2) == 0) ? {4'h0, px[11:8]} : px[7:0];
      if (href) href_n++;
      check($sformatf("%s k=%0d vsync", name, k),       16'(vsync),       16'(ev));
      check($sformatf("%s k=%0d href", name, k),        16'(href),        16'(eh));
      check($sformatf("%s k=%0d data", name, k),        16'(data),        16'(ed));
      check($sformatf("%s k=%0d frame_start", name, k), 16'(frame_start), 16'(k == 1));
      check($sformatf("%s k=%0d frame_count", name, k), frame_count,      cnt);
      if (k == evt_k) begin
        case (evt_kind)
          EV_MODE: begin mode = new_mode; solid_rgb = new_solid; end
          EV_DROP: enable = 1'b0;
          EV_RST:  begin rst = 1'b1; return; end
          default: ;
        endcase
      end
    end
    check({name, " href bytes per frame"}, 16'(href_n), 16'd64);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    mode      = 2'd3;
    solid_rgb = 12'hA5C;
    step();
    step();
    check_idle("reset", 16'h0);

    // Cycle 0: enable sampled, outputs still idle; vsync appears at cycle 1.
    rst    = 1'b0;
    enable = 1'b1;
    step();
    check_idle("cycle0", 16'h0);

    // Mode changes at k=50 only take effect from the following frame.
    run_frame("solid",   2'd3, 12'hA5C, 16'd1, 50, EV_MODE, 2'd0, 12'h000);
    run_frame("bars",    2'd0, 12'h000, 16'd2, 50, EV_MODE, 2'd1, 12'h000);
    run_frame("ramp",    2'd1, 12'h000, 16'd3, 50, EV_MODE, 2'd2, 12'h000);
    // Enable drops during active line 2; the frame still runs to the end of VFP.
    run_frame("checker", 2'd2, 12'h000, 16'd4, 85, EV_DROP, 2'd0, 12'h000);

    for (int i = 0; i < 10; i++) check_idle($sformatf("idle%0d", i), 16'd4);

    // Mode and colour set while idle are latched when the next frame starts.
    mode      = 2'd3;
    solid_rgb = 12'h123;
    enable    = 1'b1;
    step();
    check_idle("reenable", 16'd4);
    run_frame("reen", 2'd3, 12'h123, 16'd5, 70, EV_RST, 2'd0, 12'h000);

    step();
    check_idle("rst_abort", 16'h0);

    rst = 1'b0;
    step();
    check_idle("rerun_cycle0", 16'h0);
    run_frame("rerun", 2'd3, 12'h123, 16'd1, 0, EV_NONE, 2'd0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
